// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a reg_file-backed FIFO: turns push/pop requests into
// write strobe and addresses, and tracks occupancy, threshold flags and sticky errors.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = CW'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  ovf;
  logic                  udf;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  // A push into a full FIFO is still accepted when a pop frees the head slot this cycle.
  assign wr_acc = wr & (~full | rd);
  assign rd_acc = rd & ~empty;
  assign wr_en  = wr_acc & ~flush;

  assign w_addr    = w_ptr;
  assign r_addr    = r_ptr;
  assign count     = cnt;
  assign overflow  = ovf;
  assign underflow = udf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
        cnt   <= '0;
      end else begin
        if (wr_acc) w_ptr <= w_ptr + PTR_ONE;
        if (rd_acc) r_ptr <= r_ptr + PTR_ONE;
        case ({wr_acc, rd_acc})
          2'b10:   cnt <= cnt + CNT_ONE;
          2'b01:   cnt <= cnt - CNT_ONE;
          default: cnt <= cnt;
        endcase
      end

      // A new error in the same cycle as clr_err keeps the flag set.
      if (wr & ~wr_acc & ~flush) ovf <= 1'b1;
      else if (clr_err)          ovf <= 1'b0;

      if (rd & empty & ~flush)   udf <= 1'b1;
      else if (clr_err)          udf <= 1'b0;
    end
  end

endmodule
